// File: rtl/data_mem_ctrl.sv
// ============================================================================
// data_mem_ctrl : word RAM with byte lanes, valid/ready request/response,
//                 programmable wait states, debug probe and error counter
// Revision 1.0
// ============================================================================
`default_nettype none

module data_mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W/8-1:0]       req_be,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    input  logic [$clog2(DEPTH)-1:0]  probe_addr,
    output logic [DATA_W-1:0]         probe_data,
    output logic [15:0]               err_cnt
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF   = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   probe_data_q, probe_data_d;
    logic [15:0]         err_cnt_q, err_cnt_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [BE_W-1:0]     acc_be;
    logic [IDX_W-1:0]    acc_idx;
    logic                acc_err;
    logic                do_access;
    logic [DATA_W-1:0]   probe_word;

    // With zero wait states the access happens on the accept edge, so the
    // live request is used; otherwise the latched copy is used.
    assign acc_we    = (state_q == S_IDLE) ? req_we    : we_q;
    assign acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign acc_be    = (state_q == S_IDLE) ? req_be    : be_q;
    assign acc_idx   = acc_addr[OFF+IDX_W-1:OFF];
    assign acc_err   = (|acc_addr[OFF-1:0]) ||
                       (acc_addr[ADDR_W-1:OFF] >= (ADDR_W-OFF)'(DEPTH));

    generate
        if ((2 ** IDX_W) == DEPTH) begin : g_probe_full
            assign probe_word = mem[probe_addr];
        end else begin : g_probe_partial
            assign probe_word = (probe_addr < IDX_W'(DEPTH)) ? mem[probe_addr] : '0;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        err_cnt_d    = err_cnt_q;
        probe_data_d = probe_word;
        do_access    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = 4'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d   = S_RESP;
                        do_access = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = S_RESP;
                    do_access = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_access) begin
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_we || acc_err) ? '0 : mem[acc_idx];
            if (acc_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            probe_data_q <= '0;
            err_cnt_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            probe_data_q <= probe_data_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // RAM has no reset: contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (do_access && acc_we && !acc_err) begin
            for (int i = 0; i < BE_W; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign probe_data = probe_data_q;
    assign err_cnt    = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// tb_data_mem_ctrl : directed vector bench for data_mem_ctrl, three instances
//                    with WAIT_STATES = 1, 3 and 0
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

    logic        clk;
    logic [2:0]  rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_we;
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_ready;
    logic [31:0] rsp_rdata [3];
    logic [2:0]  rsp_err;
    logic [5:0]  probe_addr [3];
    logic [31:0] probe_data [3];
    logic [15:0] err_cnt    [3];

    int n_pass;
    int n_total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar u = 0; u < 3; u++) begin : g_dut
            data_mem_ctrl #(
                .DATA_W      (32),
                .DEPTH       (64),
                .ADDR_W      (32),
                .WAIT_STATES ((u == 0) ? 1 : ((u == 1) ? 3 : 0))
            ) dut (
                .clk        (clk),
                .reset      (rst_n[u]),
                .req_valid  (req_valid[u]),
                .req_ready  (req_ready[u]),
                .req_we     (req_we[u]),
                .req_addr   (req_addr[u]),
                .req_wdata  (req_wdata[u]),
                .req_be     (req_be[u]),
                .rsp_valid  (rsp_valid[u]),
                .rsp_ready  (rsp_ready[u]),
                .rsp_rdata  (rsp_rdata[u]),
                .rsp_err    (rsp_err[u]),
                .probe_addr (probe_addr[u]),
                .probe_data (probe_data[u]),
                .err_cnt    (err_cnt[u])
            );
        end
    endgenerate

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Called at a negedge with the instance idle; lat counts negedges from the
    // request cycle to the first one showing rsp_valid (expected WAIT_STATES+1).
    task automatic do_req(input int u, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output logic [31:0] pr);
        req_valid[u] = 1'b1;
        req_we[u]    = we;
        req_addr[u]  = addr;
        req_wdata[u] = wdata;
        req_be[u]    = be;
        @(negedge clk);
        req_valid[u] = 1'b0;
        lat = 1;
        while (!rsp_valid[u] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata[u];
        err   = rsp_err[u];
        pr    = probe_data[u];
        rsp_ready[u] = 1'b1;
        @(negedge clk);
        rsp_ready[u] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] pr;
        logic        er;
        int          lat;
        int          cyc;
        int          nresp;
        logic        ok;

        n_pass  = 0;
        n_total = 0;
        rst_n     = 3'b000;
        req_valid = 3'b000;
        req_we    = 3'b000;
        rsp_ready = 3'b000;
        for (int u = 0; u < 3; u++) begin
            req_addr[u]   = 32'h0;
            req_wdata[u]  = 32'h0;
            req_be[u]     = 4'h0;
            probe_addr[u] = 6'd0;
        end

        vecs[0]  = '{1'b1, 32'h054, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 32'h054, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 32'h010, 32'h11223344, 4'hF, 32'h00000000, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 32'h010, 32'hAABBCCDD, 4'h5, 32'h00000000, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 32'h010, 32'h00000000, 4'h0, 32'h11BB33DD, 1'b0, 16'd0};
        vecs[5]  = '{1'b1, 32'h000, 32'h01020304, 4'hF, 32'h00000000, 1'b0, 16'd0};
        vecs[6]  = '{1'b1, 32'h000, 32'hCAFEF00D, 4'h0, 32'h00000000, 1'b0, 16'd0};
        vecs[7]  = '{1'b0, 32'h000, 32'h00000000, 4'h0, 32'h01020304, 1'b0, 16'd0};
        vecs[8]  = '{1'b0, 32'h013, 32'h00000000, 4'h0, 32'h00000000, 1'b1, 16'd1};
        vecs[9]  = '{1'b0, 32'h100, 32'h00000000, 4'h0, 32'h00000000, 1'b1, 16'd2};
        vecs[10] = '{1'b1, 32'h102, 32'h12345678, 4'hF, 32'h00000000, 1'b1, 16'd3};
        vecs[11] = '{1'b0, 32'h000, 32'h00000000, 4'h0, 32'h01020304, 1'b0, 16'd3};
        vecs[12] = '{1'b0, 32'h010, 32'h00000000, 4'h0, 32'h11BB33DD, 1'b0, 16'd3};
        vecs[13] = '{1'b1, 32'h0FC, 32'h55667788, 4'hF, 32'h00000000, 1'b0, 16'd3};
        vecs[14] = '{1'b1, 32'h0FC, 32'hAA000000, 4'h8, 32'h00000000, 1'b0, 16'd3};
        vecs[15] = '{1'b0, 32'h0FC, 32'h00000000, 4'h0, 32'hAA667788, 1'b0, 16'd3};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'h0);
        chk("rst_req_ready", 32'(req_ready[0]), 32'h1);
        chk("rst_rsp_rdata", rsp_rdata[0], 32'h0);
        chk("rst_rsp_err",   32'(rsp_err[0]), 32'h0);
        chk("rst_probe",     probe_data[0], 32'h0);
        chk("rst_err_cnt",   32'(err_cnt[0]), 32'h0);
        rst_n = 3'b111;
        @(negedge clk);

        // Table-driven transactions on the one-wait-state instance
        for (int i = 0; i < 16; i++) begin
            do_req(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat, pr);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_err_cnt", i), 32'(err_cnt[0]), 32'(vecs[i].exp_cnt));
        end

        // Probe port reads back committed words
        probe_addr[0] = 6'd4;
        @(negedge clk);
        chk("probe_word4", probe_data[0], 32'h11BB33DD);
        probe_addr[0] = 6'd63;
        @(negedge clk);
        chk("probe_word63", probe_data[0], 32'hAA667788);

        // Probe does not see a write committed on the same edge
        probe_addr[0] = 6'd2;
        do_req(0, 1'b1, 32'h08, 32'h11111111, 4'hF, rd, er, lat, pr);
        do_req(0, 1'b1, 32'h08, 32'h22222222, 4'hF, rd, er, lat, pr);
        chk("probe_same_edge_old", pr, 32'h11111111);
        chk("probe_next_edge_new", probe_data[0], 32'h22222222);

        // Response held while rsp_ready stays low; other inputs ignored
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h54;
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h10;
        cyc = 0;
        while (!rsp_valid[0] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold_rdata", rsp_rdata[0], 32'hDEADBEEF);
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEADBEEF ||
                req_ready[0] !== 1'b0 || rsp_err[0] !== 1'b0) ok = 1'b0;
        end
        chk("hold_stable_5cyc", 32'(ok), 32'h1);
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        chk("hold_release_ready", 32'(req_ready[0]), 32'h1);
        chk("hold_release_valid", 32'(rsp_valid[0]), 32'h0);

        // Reset during the wait phase of a write drops the write
        probe_addr[1] = 6'd8;
        do_req(1, 1'b1, 32'h20, 32'h0A0A0A0A, 4'hF, rd, er, lat, pr);
        chk("ws3_latency", 32'(lat), 32'd4);
        do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, pr);
        chk("ws3_read", rd, 32'h0A0A0A0A);
        do_req(1, 1'b0, 32'h21, 32'h0, 4'h0, rd, er, lat, pr);
        chk("ws3_err_cnt", 32'(err_cnt[1]), 32'h1);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'hFFFFFFFF;
        req_be[1]    = 4'hF;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        #2;
        rst_n[1] = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid[1]), 32'h0);
        chk("arst_rsp_err",   32'(rsp_err[1]), 32'h0);
        chk("arst_err_cnt",   32'(err_cnt[1]), 32'h0);
        chk("arst_probe",     probe_data[1], 32'h0);
        chk("arst_req_ready", 32'(req_ready[1]), 32'h1);
        repeat (3) @(negedge clk);
        rst_n[1] = 1'b1;
        do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, pr);
        chk("arst_old_word", rd, 32'h0A0A0A0A);

        // Zero wait states: back-to-back reads, one response every 2 cycles
        do_req(2, 1'b1, 32'h20, 32'h600D600D, 4'hF, rd, er, lat, pr);
        chk("ws0_latency", 32'(lat), 32'd1);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b0;
        req_addr[2]  = 32'h20;
        rsp_ready[2] = 1'b1;
        nresp = 0;
        ok    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rsp_valid[2] !== ((k % 2) == 1)) ok = 1'b0;
            if (rsp_valid[2] === 1'b1) begin
                nresp++;
                if (rsp_rdata[2] !== 32'h600D600D) ok = 1'b0;
            end
        end
        req_valid[2] = 1'b0;
        rsp_ready[2] = 1'b0;
        chk("ws0_resp_count", 32'(nresp), 32'd4);
        chk("ws0_pattern", 32'(ok), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
